reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- System reset controller sitting directly downstream of the watchdog.
- Generates the watchdog's power_on_reset input, consumes the watchdog's reset output, and debounces the external reset button.
- Drives a stretched, registered sys_reset to the CPU and peripherals.
- Latches a sticky reset-cause register that software reads alongside the watchdog config byte.

Parameters:
- POR_CYCLES, 256: cycles power_on_reset stays high after a cold reset or button release.
- STRETCH_CYCLES, 64: cycles sys_reset stays high after power_on_reset falls, or after a watchdog reset pulse.
- DEBOUNCE_CYCLES, 1024: consecutive stable synchronised samples required to change the debounced button state.
- CNT_W, 16: width of the shared sequencing counter and debounce counter. All three cycle parameters must be ≥1 and ≤2^CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; raw power-up / PLL-not-locked reset
- button_n  in  1  external reset button, active-low, asynchronous to clk
- wdt_reset  in  1  reset output of watchdog (POR echo OR overflow/trap/zero-write pulse)
- cause_clear  in  1  single-cycle strobe from I/O write; clears reset_cause
- power_on_reset  out  1  to watchdog power_on_reset; cold-reset indication
- sys_reset  out  1  registered system reset to CPU and peripherals
- reset_cause  out  3  sticky {watchdog, button, power_on}
- seq_state  out  2  current state encoding, for debug/status readback

Behaviour:
- All outputs are registered.
- While reset is sampled high:
  - state=POR, counter=POR_CYCLES-1.
  - power_on_reset=1, sys_reset=1, reset_cause=3'b001.
  - Both synchroniser flops=1, debounced=released, debounce counter=0.
- Button path:
  - button_n passes through a 2-flop synchroniser.
  - The debounce counter increments while the synchronised value differs from the debounced state, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state toggles and the counter clears.
  - A press event is the debounced transition released->pressed.
- States:
  - POR=0: power_on_reset=1, sys_reset=1.
  - STRETCH=1: power_on_reset=0, sys_reset=1.
  - RUN=2: both 0.
- Transitions (priority: reset > debounced pressed > wdt_reset > counter):
  - POR: while debounced pressed, reload counter=POR_CYCLES-1 and hold. Otherwise decrement. At counter==0, go to STRETCH with counter=STRETCH_CYCLES-1. Result: exactly POR_CYCLES cycles of power_on_reset after the last cycle reset was high or the button was pressed.
  - STRETCH: a press event goes to POR (reload) and sets cause[1]. A qualified wdt_reset reloads the counter to STRETCH_CYCLES-1 and sets cause[2]. Otherwise decrement. At counter==0, go to RUN.
  - RUN: a press event goes to POR and sets cause[1]. A qualified wdt_reset goes to STRETCH (counter=STRETCH_CYCLES-1) and sets cause[2].
- wdt_reset qualification:
  - wdt_reset is ignored while power_on_reset is 1, and during the first cycle after power_on_reset falls, because the watchdog echoes POR combinationally.
  - Otherwise a single-cycle high sample is sufficient.
- Latency: wdt_reset sampled high at edge N gives sys_reset=1 from edge N (visible in the cycle after N), and it stays high for STRETCH_CYCLES cycles after the last qualified pulse.
- reset_cause:
  - Bits are sticky and cleared by cause_clear.
  - A set event in the same cycle as cause_clear wins (bit reads 1).
  - A button press also clears cause[0] and cause[2] and sets cause[1].
  - A cold reset forces 3'b001.
- Button held indefinitely: the block remains in POR with power_on_reset=1. There is no timeout.
- Counter never wraps: it is reloaded on every state entry and decrements only while nonzero.
- sys_reset=1 whenever power_on_reset=1 (invariant).

Test Plan:
All scenarios use POR_CYCLES=8, STRETCH_CYCLES=4, DEBOUNCE_CYCLES=5.
- Cold reset: reset high 3 cycles then low -> power_on_reset high exactly 8 more cycles, sys_reset high exactly 12 more cycles, then RUN; reset_cause=001, seq_state 0->1->2.
- Watchdog pulse in RUN: 1-cycle wdt_reset -> sys_reset high next cycle for exactly 4 cycles, power_on_reset stays 0; reset_cause=101.
- Retrigger: second wdt_reset on the 3rd STRETCH cycle -> sys_reset held until 4 cycles after the second pulse (6 total).
- POR masking: wdt_reset high throughout POR and on the first STRETCH cycle, then low -> STRETCH length unchanged (4), cause[2] stays 0.
- Button bounce: button_n low for 3 cycles then high -> no reset. button_n low for 20 cycles -> POR entered 7 cycles after the falling edge (2 sync + 5 debounce), power_on_reset held until 8 cycles after debounced release; reset_cause=010.
- cause_clear: cause_clear strobe in RUN -> reset_cause=000. cause_clear coincident with a qualified wdt_reset -> reset_cause=100.

Source files
------------

// File: rtl/reset_sequencer.sv
// System reset sequencer: cold-reset timing, button debounce, watchdog stretch
// and a sticky reset-cause register.
//
// state   | meaning
// POR     | power_on_reset and sys_reset asserted; cold reset or button held
// STRETCH | sys_reset asserted after POR ends or after a watchdog pulse
// RUN     | system released
module reset_sequencer #(
   parameter int POR_CYCLES      = 256,
   parameter int STRETCH_CYCLES  = 64,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_n,
   input  logic       wdt_reset,
   input  logic       cause_clear,
   output logic       power_on_reset,
   output logic       sys_reset,
   output logic [2:0] reset_cause,
   output logic [1:0] seq_state
);

   typedef enum logic [1:0] {
      POR     = 2'd0,
      STRETCH = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] POR_LOAD     = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             sync1, sync2;
   logic             deb, deb_next;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_next;
   logic             press;
   logic             mask;
   logic             wdt_qual;
   logic [2:0]       cause_next;

   // deb is the debounced "pressed" state; sync2 is the synchronised active-low button
   always_comb begin
      deb_next     = deb;
      deb_cnt_next = '0;
      press        = 1'b0;
      if ((~sync2) != deb) begin
         if (deb_cnt == DEB_LAST) begin
            deb_next = ~deb;
            press    = ~deb;
         end else begin
            deb_cnt_next = deb_cnt + ONE;
         end
      end
   end

   // The watchdog echoes power_on_reset combinationally, so its output is
   // ignored during POR and for one cycle after power_on_reset falls.
   assign wdt_qual = wdt_reset & ~power_on_reset & ~mask;

   always_comb begin
      state_next = state;
      cnt_next   = (cnt != '0) ? cnt - ONE : cnt;
      cause_next = cause_clear ? 3'b000 : reset_cause;
      case (state)
         POR: begin
            if (deb || press) begin
               cnt_next = POR_LOAD;
            end else if (cnt == '0) begin
               state_next = STRETCH;
               cnt_next   = STRETCH_LOAD;
            end
         end
         STRETCH: begin
            if (press) begin
               state_next = POR;
               cnt_next   = POR_LOAD;
            end else if (wdt_qual) begin
               cnt_next      = STRETCH_LOAD;
               cause_next[2] = 1'b1;
            end else if (cnt == '0) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (press) begin
               state_next = POR;
               cnt_next   = POR_LOAD;
            end else if (wdt_qual) begin
               state_next    = STRETCH;
               cnt_next      = STRETCH_LOAD;
               cause_next[2] = 1'b1;
            end
         end
         default: begin
            state_next = POR;
            cnt_next   = POR_LOAD;
         end
      endcase
      if (press) begin
         cause_next = 3'b010;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= POR;
         cnt            <= POR_LOAD;
         sync1          <= 1'b1;
         sync2          <= 1'b1;
         deb            <= 1'b0;
         deb_cnt        <= '0;
         mask           <= 1'b1;
         power_on_reset <= 1'b1;
         sys_reset      <= 1'b1;
         reset_cause    <= 3'b001;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         sync1          <= button_n;
         sync2          <= sync1;
         deb            <= deb_next;
         deb_cnt        <= deb_cnt_next;
         mask           <= power_on_reset;
         power_on_reset <= (state_next == POR);
         sys_reset      <= (state_next != RUN);
         reset_cause    <= cause_next;
      end
   end

   assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small cycle parameters: a cold-reset
// vector table followed by hand-written watchdog, masking, button and clear sequences.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       button_n;
   logic       wdt_reset;
   logic       cause_clear;
   logic       power_on_reset;
   logic       sys_reset;
   logic [2:0] reset_cause;
   logic [1:0] seq_state;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       rst;
      logic       btn;
      logic       wdt;
      logic       clr;
      logic       por;
      logic       sys;
      logic [2:0] cause;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[16];

   reset_sequencer #(
      .POR_CYCLES     (8),
      .STRETCH_CYCLES (4),
      .DEBOUNCE_CYCLES(5),
      .CNT_W          (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .button_n      (button_n),
      .wdt_reset     (wdt_reset),
      .cause_clear   (cause_clear),
      .power_on_reset(power_on_reset),
      .sys_reset     (sys_reset),
      .reset_cause   (reset_cause),
      .seq_state     (seq_state)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic b, input logic w, input logic c);
      reset       = r;
      button_n    = b;
      wdt_reset   = w;
      cause_clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic por, input logic sys,
                      input logic [2:0] cause, input logic [1:0] st);
      total++;
      if ({power_on_reset, sys_reset, reset_cause, seq_state} === {por, sys, cause, st})
         passed++;
      else
         $display("FAIL %s: got por=%b sys=%b cause=%b st=%0d, expected por=%b sys=%b cause=%b st=%0d",
                  name, power_on_reset, sys_reset, reset_cause, seq_state, por, sys, cause, st);
   endtask

   initial begin
      // Cold reset: 3 reset rows, 7 more POR rows, 4 STRETCH rows, then RUN.
      for (int i = 0; i < 16; i++) begin
         tbl[i].rst   = (i < 3);
         tbl[i].btn   = 1'b1;
         tbl[i].wdt   = 1'b0;
         tbl[i].clr   = 1'b0;
         tbl[i].cause = 3'b001;
         if (i < 10) begin
            tbl[i].por = 1'b1; tbl[i].sys = 1'b1; tbl[i].st = 2'd0;
         end else if (i < 14) begin
            tbl[i].por = 1'b0; tbl[i].sys = 1'b1; tbl[i].st = 2'd1;
         end else begin
            tbl[i].por = 1'b0; tbl[i].sys = 1'b0; tbl[i].st = 2'd2;
         end
      end

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst, tbl[i].btn, tbl[i].wdt, tbl[i].clr);
         chk($sformatf("cold_row%0d", i), tbl[i].por, tbl[i].sys, tbl[i].cause, tbl[i].st);
      end

      // Single watchdog pulse in RUN
      step(0, 1, 1, 0); chk("wdt_enter", 0, 1, 3'b101, 2'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0); chk("wdt_stretch", 0, 1, 3'b101, 2'd1);
      end
      step(0, 1, 0, 0); chk("wdt_run", 0, 0, 3'b101, 2'd2);

      // Retrigger: 2 cycles, then a second pulse, then 4 more cycles
      step(0, 1, 1, 0); chk("retrig_first", 0, 1, 3'b101, 2'd1);
      step(0, 1, 0, 0); chk("retrig_gap", 0, 1, 3'b101, 2'd1);
      step(0, 1, 1, 0); chk("retrig_second", 0, 1, 3'b101, 2'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0); chk("retrig_hold", 0, 1, 3'b101, 2'd1);
      end
      step(0, 1, 0, 0); chk("retrig_run", 0, 0, 3'b101, 2'd2);

      // cause_clear alone, then coincident with a qualified watchdog pulse
      step(0, 1, 0, 1); chk("clear_run", 0, 0, 3'b000, 2'd2);
      step(0, 1, 1, 1); chk("clear_vs_wdt", 0, 1, 3'b100, 2'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0); chk("clear_stretch", 0, 1, 3'b100, 2'd1);
      end
      step(0, 1, 0, 0); chk("clear_back_run", 0, 0, 3'b100, 2'd2);

      // POR masking: wdt_reset held through POR and the first STRETCH cycle
      step(1, 1, 1, 0); chk("mask_reset", 1, 1, 3'b001, 2'd0);
      for (int i = 0; i < 7; i++) begin
         step(0, 1, 1, 0); chk("mask_por", 1, 1, 3'b001, 2'd0);
      end
      step(0, 1, 1, 0); chk("mask_stretch1", 0, 1, 3'b001, 2'd1);
      step(0, 1, 1, 0); chk("mask_stretch2", 0, 1, 3'b001, 2'd1);
      step(0, 1, 0, 0); chk("mask_stretch3", 0, 1, 3'b001, 2'd1);
      step(0, 1, 0, 0); chk("mask_stretch4", 0, 1, 3'b001, 2'd1);
      step(0, 1, 0, 0); chk("mask_run", 0, 0, 3'b001, 2'd2);

      // Short bounce: no reset
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0); chk("bounce_low", 0, 0, 3'b001, 2'd2);
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 0); chk("bounce_high", 0, 0, 3'b001, 2'd2);
      end

      // Long press: POR 7 cycles after the falling edge
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0); chk("press_wait", 0, 0, 3'b001, 2'd2);
      end
      step(0, 0, 0, 0); chk("press_enter_por", 1, 1, 3'b010, 2'd0);
      for (int i = 0; i < 13; i++) begin
         step(0, 0, 0, 0); chk("press_held", 1, 1, 3'b010, 2'd0);
      end
      // Release: debounced after 7 cycles, then 8 POR cycles
      for (int i = 0; i < 14; i++) begin
         step(0, 1, 0, 0); chk("release_por", 1, 1, 3'b010, 2'd0);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0); chk("release_stretch", 0, 1, 3'b010, 2'd1);
      end
      step(0, 1, 0, 0); chk("release_run", 0, 0, 3'b010, 2'd2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
